gfb_dbuf: RTL

- Parametrised successor to the single-page graphics memory: a UIB-standard slave framebuffer with SLICE_NR pixel-wide lane slices.
- Two pages (front/back); the display reads the front page, the bus reads/writes the back page.
- A page flip is requested by software and committed on the next vsync pulse.
- Bus readback is supported (the previous generation blocked bus reads).
- Sits between the UIB interconnect and the VGA controller.

---
 rtl/gfb_dbuf_pkg.sv | 16 +
 rtl/gfb_dbuf_if.sv | 26 ++
 rtl/gfb_dbuf_slice.sv | 26 ++
 rtl/gfb_dbuf.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/gfb_dbuf_pkg.sv
// Shared types and helpers for the double-buffered framebuffer.
// Holds the FSM state encodings and the lane-index helper.
package gfb_pkg;

    localparam int SLICE_NR_DEF = 4;
    localparam int SLICE_W      = $clog2(SLICE_NR_DEF);

    typedef enum logic {FLIP_IDLE, FLIP_PENDING} flip_st_t;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_st_t;

    // Lane (slice) selected by the low bits of a pixel address.
    function automatic int unsigned slice_idx(input int unsigned addr, input int unsigned w = SLICE_W);
        return addr & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/gfb_dbuf_if.sv
// UIB slave bus bundle for the framebuffer: request side from the interconnect, ack/data back.
// Ready is driven by the slave; ack/data are registered completions.
interface gfb_dbuf_if #(
    parameter int ADDR_W   = 17,
    parameter int XLEN     = 32,
    parameter int SLICE_NR = 4
);
    logic [ADDR_W-1:0]   bus_addr;
    logic [XLEN-1:0]     bus_dat_i;
    logic [SLICE_NR-1:0] bus_sel;
    logic                bus_wen;
    logic                bus_ren;
    logic                bus_ready;
    logic                bus_ack;
    logic [XLEN-1:0]     bus_dat_o;

    modport master (
        output bus_addr, bus_dat_i, bus_sel, bus_wen, bus_ren,
        input  bus_ready, bus_ack, bus_dat_o
    );

    modport slave (
        input  bus_addr, bus_dat_i, bus_sel, bus_wen, bus_ren,
        output bus_ready, bus_ack, bus_dat_o
    );
endinterface

// File: rtl/gfb_dbuf_slice.sv
// One pixel lane of both pages: simple dual-port RAM, port A write/read-first, port B read.
// Latency 1 on both read ports (registered outputs); no backpressure.
module gfb_slice #(
    parameter int PIX_W = 8,
    parameter int WORDS = 19200,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [PIX_W-1:0] a_wdat,
    output logic [PIX_W-1:0] a_q,
    input  logic [IDX_W-1:0] b_idx,
    output logic [PIX_W-1:0] b_q
);
    logic [PIX_W-1:0] mem [2*WORDS];

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) mem[a_idx] <= a_wdat;
            a_q <= mem[a_idx];
        end
        b_q <= mem[b_idx];
    end
endmodule

// File: rtl/gfb_dbuf.sv
// Two-page framebuffer: bus owns the back page (write ack +1, read ack +2, ready drops 1 cycle per read),
// display reads the front page with latency 2; vsync-committed flips; optional back-page clear under GFB_CLEAR_EN.
module gfb_dbuf import gfb_pkg::*; #(
    parameter int PIX_W    = 8,
    parameter int SLICE_NR = 4,
    parameter int DEPTH    = 76800,
    parameter int ADDR_W   = 17,
    parameter int XLEN     = 32
) (
    input  logic              clk,
    input  logic              rst,
    gfb_dbuf_if.slave         bus,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [PIX_W-1:0]  vga_dat,
    input  logic              vsync,
    input  logic              flip_req,
    output logic              flip_pending,
    output logic              front_page,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_color,
    output logic              clr_busy
);
    localparam int SW    = $clog2(SLICE_NR);
    localparam int WORDS = DEPTH / SLICE_NR;
    localparam int IDX_W = $clog2(2 * WORDS);
    localparam int WA_W  = ADDR_W - SW;

    // Pages are stacked linearly so each slice holds exactly two pages of words.
    function automatic logic [IDX_W-1:0] word_idx(input logic page, input logic [ADDR_W-1:0] a);
        if (a >= ADDR_W'(DEPTH)) return '0;
        return (page ? IDX_W'(WORDS) : '0) + IDX_W'(a[ADDR_W-1:SW]);
    endfunction

    logic                bus_oor, wr_acc, rd_acc, ready_r;
    logic                rd_v1, rd_oor1, vga_oor1;
    logic [SW-1:0]       vga_lane1;
    logic                a_en, a_we;
    logic [IDX_W-1:0]    a_idx, b_idx;
    logic [XLEN-1:0]     a_wdat, a_cat;
    logic [SLICE_NR-1:0] a_sel;
    logic [PIX_W-1:0]    a_q [SLICE_NR];
    logic [PIX_W-1:0]    b_q [SLICE_NR];
    logic                clr_hold, flip_blk;
    flip_st_t            flip_st;

    assign bus_oor       = bus.bus_addr >= ADDR_W'(DEPTH);
    assign wr_acc        = bus.bus_wen && ready_r;
    assign rd_acc        = bus.bus_ren && ready_r && !bus.bus_wen;
    assign bus.bus_ready = ready_r;
    assign b_idx         = word_idx(front_page, vga_addr);

`ifdef GFB_CLEAR_EN
    clr_st_t          clr_st;
    logic [WA_W-1:0]  clr_cnt;
    logic             clr_page;
    logic [PIX_W-1:0] clr_col;

    assign clr_hold = (clr_st == CLR_IDLE && clr_req) ||
                      (clr_st == CLR_RUN && clr_cnt != WA_W'(WORDS - 1));
    assign flip_blk = (clr_st == CLR_RUN);
`else
    logic unused_clr;
    assign unused_clr = ^{clr_req, clr_color};
    assign clr_hold   = 1'b0;
    assign flip_blk   = 1'b0;
    assign clr_busy   = 1'b0;
`endif

    always_comb begin
        a_en   = wr_acc || rd_acc;
        a_we   = wr_acc && !bus_oor;
        a_idx  = word_idx(~front_page, bus.bus_addr);
        a_wdat = bus.bus_dat_i;
        a_sel  = bus.bus_sel;
`ifdef GFB_CLEAR_EN
        // Bus is held off while clearing, so the clear owns port A outright.
        if (clr_st == CLR_RUN) begin
            a_en   = 1'b1;
            a_we   = 1'b1;
            a_idx  = (clr_page ? IDX_W'(WORDS) : '0) + IDX_W'(clr_cnt);
            a_wdat = {SLICE_NR{clr_col}};
            a_sel  = '1;
        end
`endif
    end

    always_comb begin
        a_cat = '0;
        for (int i = 0; i < SLICE_NR; i++) a_cat[i*PIX_W +: PIX_W] = a_q[i];
    end

    for (genvar i = 0; i < SLICE_NR; i++) begin : g_slice
        gfb_slice #(.PIX_W(PIX_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_slice (
            .clk    (clk),
            .a_en   (a_en),
            .a_we   (a_we && a_sel[i]),
            .a_idx  (a_idx),
            .a_wdat (a_wdat[i*PIX_W +: PIX_W]),
            .a_q    (a_q[i]),
            .b_idx  (b_idx),
            .b_q    (b_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_r       <= 1'b0;
            rd_v1         <= 1'b0;
            rd_oor1       <= 1'b0;
            bus.bus_ack   <= 1'b0;
            bus.bus_dat_o <= '0;
            vga_oor1      <= 1'b0;
            vga_lane1     <= '0;
            vga_dat       <= '0;
            flip_st       <= FLIP_IDLE;
            flip_pending  <= 1'b0;
            front_page    <= 1'b0;
        end else begin
            ready_r     <= !rd_acc && !clr_hold;
            rd_v1       <= rd_acc;
            rd_oor1     <= bus_oor;
            bus.bus_ack <= wr_acc || rd_v1;
            if (rd_v1) bus.bus_dat_o <= rd_oor1 ? '0 : a_cat;

            vga_oor1  <= vga_addr >= ADDR_W'(DEPTH);
            vga_lane1 <= SW'(slice_idx(32'(vga_addr), SW));
            vga_dat   <= vga_oor1 ? '0 : b_q[vga_lane1];

            case (flip_st)
                FLIP_IDLE: if (flip_req) begin
                    flip_st      <= FLIP_PENDING;
                    flip_pending <= 1'b1;
                end
                FLIP_PENDING: if (vsync && !flip_blk) begin
                    flip_st      <= FLIP_IDLE;
                    flip_pending <= 1'b0;
                    front_page   <= ~front_page;
                end
                default: flip_st <= FLIP_IDLE;
            endcase
        end
    end

`ifdef GFB_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_st   <= CLR_IDLE;
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
            clr_page <= 1'b0;
            clr_col  <= '0;
        end else begin
            case (clr_st)
                CLR_IDLE: if (clr_req) begin
                    clr_st   <= CLR_RUN;
                    clr_busy <= 1'b1;
                    clr_cnt  <= '0;
                    clr_page <= ~front_page;
                    clr_col  <= clr_color;
                end
                CLR_RUN: if (clr_cnt == WA_W'(WORDS - 1)) begin
                    clr_st   <= CLR_IDLE;
                    clr_busy <= 1'b0;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
                default: clr_st <= CLR_IDLE;
            endcase
        end
    end
`endif
endmodule
